multicycle_sequencer: RTL and testbench

Issue controller between the i281 instruction decoder and the multicycle arithmetic unit. It accepts one 8-bit multicycle instruction at a time and stalls the CPU while the instruction runs. It fetches the two register operands, starts the unit, waits for its done trigger, then writes the result and flags back. It rejects illegal opcodes and, when configured, aborts operations that never complete.

---
 rtl/multicycle_pkg.sv | 30 +++
 rtl/mc_watchdog.sv | 37 +++
 rtl/multicycle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle issue sequencer: opcodes, FSM states,
// instruction field positions and the legal-opcode test.
package multicycle_pkg;

  localparam logic [3:0] OP_GCD  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_RAND = 4'd5;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RA_MSB  = 3;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPS   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    WB    = 3'd4
  } state_e;

  function automatic logic is_legal(input logic [3:0] opc);
    return (opc >= OP_GCD) && (opc <= OP_RAND);
  endfunction

endpackage

// File: rtl/mc_watchdog.sv
// WAIT-state watchdog: counts enabled cycles after a clear and flags expiry
// once LIMIT cycles have elapsed. Only instantiated when MC_TIMEOUT_EN is defined.
module mc_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LIMIT_C);

endmodule

// File: rtl/multicycle_sequencer.sv
// Issue controller for the i281 multicycle unit: fetch operands, start, wait, write back.
// Optional WAIT watchdog compiled in with MC_TIMEOUT_EN.
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ack,
  output logic       cpu_stall,
  output logic       busy,
  output logic       err,
  output logic [1:0] reg_rd_sel_a,
  output logic [1:0] reg_rd_sel_b,
  input  logic [7:0] reg_rdata_a,
  input  logic [7:0] reg_rdata_b,
  output logic       mc_start,
  output logic [3:0] mc_opcode,
  output logic [7:0] mc_op_a,
  output logic [7:0] mc_op_b,
  input  logic       mc_done,
  input  logic [7:0] mc_result,
  input  logic [3:0] mc_flags,
  output logic       wb_en,
  output logic [1:0] wb_sel,
  output logic [7:0] wb_data,
  output logic       flags_we,
  output logic [3:0] flags_out,
  output state_e     dbg_state
);

  state_e     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic [7:0] res_q, res_d;
  logic [3:0] flags_q, flags_d;
  logic       accept;
  logic       legal;
  logic       wd_expire;
  logic       wd_clear;
  logic       wd_enable;

  assign accept   = (state_q == IDLE) && instr_valid && run;
  assign legal    = is_legal(instr[OPC_MSB:OPC_LSB]);
  assign wd_clear  = (state_q == ISSUE);
  assign wd_enable = (state_q == WAIT);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_d        = res_q;
    flags_d      = flags_q;
    instr_ack    = 1'b0;
    err          = 1'b0;
    mc_start     = 1'b0;
    wb_en        = 1'b0;
    wb_sel       = 2'b00;
    flags_we     = 1'b0;
    reg_rd_sel_a = instr_q[RA_MSB:RA_LSB];
    reg_rd_sel_b = instr_q[RB_MSB:RB_LSB];
    case (state_q)
      IDLE: begin
        reg_rd_sel_a = 2'b00;
        reg_rd_sel_b = 2'b00;
        if (accept) begin
          if (legal) begin
            instr_d      = instr;
            reg_rd_sel_a = instr[RA_MSB:RA_LSB];
            reg_rd_sel_b = instr[RB_MSB:RB_LSB];
            state_d      = OPS;
          end else begin
            err       = 1'b1;
            instr_ack = 1'b1;
          end
        end
      end
      OPS: begin
        // RAND carries its seed in the low instruction nibble instead of registers.
        if (instr_q[OPC_MSB:OPC_LSB] == OP_RAND) begin
          op_a_d = {4'b0000, instr_q[3:0]};
          op_b_d = 8'd0;
        end else begin
          op_a_d = reg_rdata_a;
          op_b_d = reg_rdata_b;
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        mc_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mc_done) begin
          res_d   = mc_result;
          flags_d = mc_flags;
          state_d = WB;
        end else if (wd_expire) begin
          err       = 1'b1;
          instr_ack = 1'b1;
          state_d   = IDLE;
        end
      end
      WB: begin
        wb_en     = 1'b1;
        flags_we  = 1'b1;
        instr_ack = 1'b1;
        wb_sel    = (instr_q[OPC_MSB:OPC_LSB] == OP_RAND) ? 2'b00 : instr_q[RA_MSB:RA_LSB];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= 8'd0;
      op_a_q  <= 8'd0;
      op_b_q  <= 8'd0;
      res_q   <= 8'd0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // Stall combinationally in the accept cycle so the CPU never runs past the instruction.
  assign busy      = (state_q != IDLE);
  assign cpu_stall = busy || (accept && legal);
  assign mc_opcode = instr_q[OPC_MSB:OPC_LSB];
  assign mc_op_a   = op_a_q;
  assign mc_op_b   = op_b_q;
  assign wb_data   = res_q;
  assign flags_out = flags_q;
  assign dbg_state = state_q;

`ifdef MC_TIMEOUT_EN
  mc_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expire  (wd_expire)
  );
`else
  logic unused_wd;
  assign unused_wd = wd_clear ^ wd_enable ^ (^TIMEOUT_CYCLES);
  assign wd_expire = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer with a register-file stand-in,
// an operation-level reference model and a write-back scoreboard.
module tb_multicycle_sequencer;
  import multicycle_pkg::*;

  localparam int TO = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'd0;
  logic       instr_ack, cpu_stall, busy, err;
  logic [1:0] reg_rd_sel_a, reg_rd_sel_b;
  logic [7:0] reg_rdata_a = 8'd0;
  logic [7:0] reg_rdata_b = 8'd0;
  logic       mc_start;
  logic [3:0] mc_opcode;
  logic [7:0] mc_op_a, mc_op_b;
  logic       mc_done = 1'b0;
  logic [7:0] mc_result = 8'd0;
  logic [3:0] mc_flags = 4'd0;
  logic       wb_en, flags_we;
  logic [1:0] wb_sel;
  logic [7:0] wb_data;
  logic [3:0] flags_out;
  state_e     dbg_state;

  logic [7:0]  regs [4];
  logic [13:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;

  multicycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .instr_valid(instr_valid), .instr(instr),
    .instr_ack(instr_ack), .cpu_stall(cpu_stall), .busy(busy), .err(err),
    .reg_rd_sel_a(reg_rd_sel_a), .reg_rd_sel_b(reg_rd_sel_b),
    .reg_rdata_a(reg_rdata_a), .reg_rdata_b(reg_rdata_b),
    .mc_start(mc_start), .mc_opcode(mc_opcode), .mc_op_a(mc_op_a), .mc_op_b(mc_op_b),
    .mc_done(mc_done), .mc_result(mc_result), .mc_flags(mc_flags),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flags_we(flags_we),
    .flags_out(flags_out), .dbg_state(dbg_state)
  );

  // clock / time bound
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL time_bound got=running exp=finished");
    $fatal(1, "time bound expired");
  end

  // register file stand-in: read data one cycle after select
  always @(posedge clock) begin
    reg_rdata_a <= regs[reg_rd_sel_a];
    reg_rdata_b <= regs[reg_rd_sel_b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (mc_start) start_cnt++;
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(wb_en), 64'd0);
        end else begin
          logic [13:0] e;
          e = exp_q.pop_front();
          check("wb_bundle", {wb_sel, flags_out, wb_data, flags_we, instr_ack, err},
                {e, 1'b1, 1'b1, 1'b0});
        end
      end
    end
  end

  function automatic logic [7:0] ref_result(input logic [3:0] opc, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [7:0] x, y, t;
    case (opc)
      OP_GCD: begin
        x = a; y = b;
        for (int k = 0; k < 300 && y != 0; k++) begin t = x % y; x = y; y = t; end
        return x;
      end
      OP_MUL:  return 8'((16'(a) * 16'(b)) & 16'hFF);
      OP_DIV:  return (b == 0) ? 8'hFF : a / b;
      OP_MOD:  return (b == 0) ? a : a % b;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic garbage();
    instr_valid = 1'($urandom);
    instr       = 8'($urandom);
    run         = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, instr_ack, cpu_stall, busy, err, reg_rd_sel_a, reg_rd_sel_b, mc_start,
            mc_opcode, mc_op_a, mc_op_b, wb_en, wb_sel, wb_data, flags_we, flags_out};
  endfunction

  // mode 0: normal completion, 1: reset in WAIT then late done, 2: watchdog expiry
  task automatic do_op(input logic [7:0] ins, input int wait_cycles, input bit stray,
                       input int mode);
    logic [3:0] opc;
    logic [7:0] ea, eb, er;
    logic [1:0] esel;
    logic [3:0] ef;
    int s0;
    opc  = ins[7:4];
    ea   = (opc == OP_RAND) ? {4'h0, ins[3:0]} : regs[ins[3:2]];
    eb   = (opc == OP_RAND) ? 8'h00 : regs[ins[1:0]];
    esel = (opc == OP_RAND) ? 2'b00 : ins[3:2];
    er   = ref_result(opc, ea, eb);
    ef   = 4'($urandom);
    s0   = start_cnt;
    instr_valid = 1'b1; instr = ins; run = 1'b1; mc_done = stray;
    @(negedge clock);
    check("acc_stall_err", {cpu_stall, err, instr_ack, busy}, 4'b1000);
    check("acc_sel", {reg_rd_sel_a, reg_rd_sel_b}, 4'(ins[3:0]));
    step(); garbage(); mc_done = 1'b0;
    @(negedge clock);
    check("ops_busy", {busy, cpu_stall, mc_start}, 3'b110);
    step(); garbage(); mc_done = stray;
    @(negedge clock);
    check("issue_start", mc_start, 1'b1);
    check("issue_ops", {mc_opcode, mc_op_a, mc_op_b}, {opc, ea, eb});
    step(); garbage(); mc_done = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clock);
      check("wait_hold", {busy, cpu_stall, err, instr_ack, mc_start, mc_opcode, mc_op_a, mc_op_b},
            {5'b11000, opc, ea, eb});
      step(); garbage();
    end
    if (mode == 1) begin
      reset_n = 1'b0; instr_valid = 1'b0;
      #1;
      check("rst_mid_outs", all_outs(), 64'd0);
      step(); reset_n = 1'b1; mc_done = 1'b1; mc_result = er; mc_flags = ef; instr_valid = 1'b0;
      @(negedge clock);
      check("late_done_idle", {busy, wb_en, dbg_state}, {2'b00, IDLE});
      step(); mc_done = 1'b0;
    end else if (mode == 2) begin
      instr_valid = 1'b0;
      @(negedge clock);
      check("timeout_pulse", {err, instr_ack, wb_en, flags_we}, 4'b1100);
      step();
      @(negedge clock);
      check("timeout_idle", {busy, cpu_stall, err}, 3'b000);
      step();
    end else begin
      mc_done = 1'b1; mc_result = er; mc_flags = ef;
      exp_q.push_back({esel, ef, er});
      @(negedge clock);
      check("done_no_wb", wb_en, 1'b0);
      step(); mc_done = 1'b0; mc_result = 8'($urandom); mc_flags = 4'($urandom);
      @(negedge clock);
      check("wb_stall", {wb_en, cpu_stall, err}, 3'b110);
      step();
      check("start_once", 64'(start_cnt - s0), 64'd1);
      check("sb_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic idle_check();
    instr_valid = 1'b0; mc_done = 1'($urandom);
    @(negedge clock);
    check("idle_quiet", {busy, cpu_stall, err, instr_ack, mc_start}, 5'b00000);
    step(); mc_done = 1'b0;
  endtask

  task automatic do_illegal(input logic [7:0] ins);
    int s0;
    s0 = start_cnt;
    instr_valid = 1'b1; instr = ins; run = 1'b1; mc_done = 1'b0;
    @(negedge clock);
    check("illegal_pulse", {err, instr_ack, cpu_stall, busy}, 4'b1100);
    step(); instr_valid = 1'b0;
    @(negedge clock);
    check("illegal_after", {err, instr_ack, busy, dbg_state}, {3'b000, IDLE});
    step();
    check("illegal_no_start", 64'(start_cnt - s0), 64'd0);
  endtask

  task automatic do_norun(input logic [7:0] ins);
    instr_valid = 1'b1; instr = ins; run = 1'b0;
    @(negedge clock);
    check("norun_stall", {cpu_stall, err, instr_ack}, 3'b000);
    step(); instr_valid = 1'b0;
    @(negedge clock);
    check("norun_idle", busy, 1'b0);
    step();
  endtask

  function automatic logic [7:0] rand_legal();
    logic [3:0] o;
    o = 4'($urandom_range(1, 5));
    return {o, 4'($urandom)};
  endfunction

  initial begin
    for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
    #3;
    @(negedge clock);
    check("reset_outs", all_outs(), 64'd0);
    check("reset_state", dbg_state, IDLE);
    step(); reset_n = 1'b1;
    step();
    idle_check();

    regs[1] = 8'd3; regs[2] = 8'd4;
    do_op(8'h26, 4, 1'b0, 0);
    idle_check();
    do_op(8'h5A, 2, 1'b0, 0);
    do_illegal(8'h70);
    do_op(8'h26, 3, 1'b1, 0);
    do_op(8'h1B, 2, 1'b0, 1);
    do_op(8'h26, 1, 1'b0, 0);
    do_norun(8'h26);
`ifdef MC_TIMEOUT_EN
    do_op(8'h3E, TO, 1'b0, 2);
`else
    do_op(8'h3E, 40, 1'b0, 0);
`endif
    idle_check();

    for (int n = 0; n < 60; n++) begin
      int sel;
      for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        logic [3:0] o;
        o = 4'($urandom_range(0, 10));
        do_illegal({(o == 0) ? 4'd0 : 4'(o + 4'd5), 4'($urandom)});
      end else if (sel == 1) begin
        do_norun(rand_legal());
      end else if (sel == 2) begin
        do_op(rand_legal(), $urandom_range(1, 6), 1'($urandom), 1);
      end else begin
        do_op(rand_legal(), $urandom_range(0, 9), 1'($urandom), 0);
      end
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
